// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch stage. Owns the PC, issues in-order word
//            requests to instruction memory, buffers responses in an
//            in-order queue and hands {inst, inst_addr} pairs to if_id.
//            Redirects from execute flush queued and in-flight fetches.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        queue entries + outstanding requests (power of two, >= 2)
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   jump_en_i    redirect request          jump_addr_i  redirect target
//   req_valid_o  fetch request valid       req_addr_o   fetch address
//   req_ready_i  memory accepts request
//   rsp_valid_i  memory response valid     rsp_data_i   instruction word
//   inst_valid_o pair valid to if_id       inst_o       instruction
//   inst_addr_o  PC of inst_o              inst_ready_i if_id accepts pair
// Configuration macro
//   FETCH_BYPASS_EN  when defined, a response arriving into an empty queue
//                    with if_id ready is forwarded combinationally.
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam int unsigned c_cw = c_aw + 1;
  localparam logic [31:0] c_nop = 32'h0000_0013;
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  // inflight counts every accepted request without a response yet, including
  // the stale ones that will be discarded after a redirect.
  logic [c_cw-1:0]   inflight_q, inflight_d;
  logic [c_cw-1:0]   discard_q, discard_d;
  logic [c_cw-1:0]   occ_q, occ_d;

  // Pending-address FIFO: holds addresses of live (non-stale) requests only.
  logic [31:0]       pend_mem_q [DEPTH];
  logic [c_aw-1:0]   pend_wr_q, pend_wr_d;
  logic [c_aw-1:0]   pend_rd_q, pend_rd_d;

  // Response queue of {addr, inst} pairs.
  logic [31:0]       q_addr_q [DEPTH];
  logic [31:0]       q_data_q [DEPTH];
  logic [c_aw-1:0]   q_wr_q, q_wr_d;
  logic [c_aw-1:0]   q_rd_q, q_rd_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        w_credit;
  logic        w_req_fire;
  logic        w_rsp_fire;
  logic        w_rsp_live;
  logic        w_q_valid;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_rsp_addr;
  logic        w_unused_jump_lsbs;

  // Credit uses registered counts only, so a pop this cycle frees a slot
  // next cycle and the request channel never depends on inst_ready_i.
  assign w_credit    = ({1'b0, inflight_q} + {1'b0, occ_q}) < c_depth;
  assign req_valid_o = (state_q != ST_WAIT) & ~jump_en_i & w_credit;
  assign req_addr_o  = pc_q;
  assign w_req_fire  = req_valid_o & req_ready_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_fire  = rsp_valid_i & (inflight_q != '0);
  // A live response belongs to a request issued after the last redirect.
  // Responses landing in a redirect cycle are dropped as well.
  assign w_rsp_live  = w_rsp_fire & (discard_q == '0) & ~jump_en_i;
  assign w_rsp_addr  = pend_mem_q[pend_rd_q];

  assign w_q_valid   = (occ_q != '0);
  assign w_pop       = w_q_valid & inst_ready_i;
  assign w_push      = w_rsp_live & ~w_bypass;

  // Low address bits of the redirect target are forced to zero.
  assign w_unused_jump_lsbs = ^jump_addr_i[1:0];

  // --------------------------------------------------------------------------
  // Output path
  // --------------------------------------------------------------------------
`ifdef FETCH_BYPASS_EN
  // Forward a live response straight to if_id when nothing is queued ahead
  // of it and if_id takes it this cycle; the pair is never written.
  assign w_bypass     = w_rsp_live & ~w_q_valid & inst_ready_i;
  assign inst_valid_o = w_q_valid | w_bypass;
  assign inst_o       = w_q_valid ? q_data_q[q_rd_q] :
                        (w_bypass ? rsp_data_i : c_nop);
  assign inst_addr_o  = w_q_valid ? q_addr_q[q_rd_q] :
                        (w_bypass ? w_rsp_addr : 32'h0000_0000);
`else
  assign w_bypass     = 1'b0;
  assign inst_valid_o = w_q_valid;
  assign inst_o       = w_q_valid ? q_data_q[q_rd_q] : c_nop;
  assign inst_addr_o  = w_q_valid ? q_addr_q[q_rd_q] : 32'h0000_0000;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    occ_d      = occ_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;

    if (w_req_fire) begin
      pc_d       = pc_q + 32'd4;
      inflight_d = inflight_d + c_cw'(1);
      pend_wr_d  = pend_wr_q + c_aw'(1);
    end

    if (w_rsp_fire) begin
      inflight_d = inflight_d - c_cw'(1);
    end

    // Stale responses have no entry in the pending FIFO (it was cleared on
    // the redirect), so only live responses advance its read pointer.
    if (w_rsp_live) begin
      pend_rd_d = pend_rd_q + c_aw'(1);
    end

    if (w_rsp_fire && (discard_q != '0)) begin
      discard_d = discard_q - c_cw'(1);
    end

    if (w_push) begin
      q_wr_d = q_wr_q + c_aw'(1);
    end
    if (w_pop) begin
      q_rd_d = q_rd_q + c_aw'(1);
    end
    occ_d = occ_q + c_cw'(w_push) - c_cw'(w_pop);

    case (state_q)
      ST_WAIT:  state_d = ST_RUN;
      ST_FLUSH: if (discard_d == '0) state_d = ST_RUN;
      default:  state_d = state_q;
    endcase

    // Redirect overrides everything above. No request can be accepted in a
    // redirect cycle, so inflight_d here is inflight minus this response.
    if (jump_en_i) begin
      pc_d      = {jump_addr_i[31:2], 2'b00};
      discard_d = inflight_d;
      pend_wr_d = '0;
      pend_rd_d = '0;
      q_wr_d    = '0;
      q_rd_d    = '0;
      occ_d     = '0;
      state_d   = (inflight_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      occ_q      <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      occ_q      <= occ_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
    end
  end

  // Storage arrays need no reset: validity is tracked by the pointers and
  // counters above.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      pend_mem_q[pend_wr_q] <= req_addr_o;
    end
    if (w_push) begin
      q_addr_q[q_wr_q] <= w_rsp_addr;
      q_data_q[q_wr_q] <= rsp_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A behavioural memory with
//            random in-order latency answers fetches; the reference model is
//            the architectural fetch stream: outputs must be consecutive
//            words from the reset PC, restarting at each redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ready_i (inst_ready_i)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Memory model: accepted requests with the cycle their response is due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;

  // Stimulus knobs
  int lat_min = 1, lat_max = 1, p_rr = 100, p_ir = 100, p_jump = 0;

  // Reference model state
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] exp_pc   = RESET_PC;
  logic        jump_prev = 1'b0, rv_prev = 1'b0, rr_prev = 1'b0;
  logic [31:0] ra_prev = '0;
  int          n_out = 0;

  // Values sampled in the most recent cycle
  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_ia, s_io;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_next();
    req_ready_i  = (int'($urandom_range(99)) < p_rr);
    inst_ready_i = (int'($urandom_range(99)) < p_ir);
    jump_en_i    = 1'b0;
    if (p_jump > 0 && int'($urandom_range(99)) < p_jump) begin
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = memword(mq[0].addr);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model
  // past the rising edge, then choose inputs for the next cycle.
  task automatic cycle();
    logic        s_rsp, s_j, s_rr, s_ir;
    logic [31:0] s_tgt;
    @(negedge clk);
    s_rv  = req_valid_o;  s_ra = req_addr_o;
    s_iv  = inst_valid_o; s_io = inst_o; s_ia = inst_addr_o;
    s_rsp = rsp_valid_i;  s_j  = jump_en_i;
    s_rr  = req_ready_i;  s_ir = inst_ready_i;
    s_tgt = {jump_addr_i[31:2], 2'b00};

    if (s_iv) begin
      chk("out_addr", s_ia, exp_addr);
      chk("out_data", s_io, memword(exp_addr));
      if (s_ir) begin
        exp_addr = exp_addr + 32'd4;
        n_out++;
      end
    end else begin
      chk("idle_inst", s_io, NOP);
      chk("idle_addr", s_ia, 32'd0);
    end
    if (jump_prev) chk("valid_after_jump", 32'(s_iv), 32'd0);
    if (s_j) begin
      chk("no_req_on_jump", 32'(s_rv), 32'd0);
    end else if (rv_prev && !rr_prev) begin
      chk("req_hold_valid", 32'(s_rv), 32'd1);
      chk("req_hold_addr", s_ra, ra_prev);
    end
    if (s_rv) begin
      chk("req_addr", s_ra, exp_pc);
      if (s_rr) exp_pc = exp_pc + 32'd4;
    end

    jump_prev = s_j; rv_prev = s_rv; rr_prev = s_rr; ra_prev = s_ra;
    if (s_j) begin
      exp_addr = s_tgt;
      exp_pc   = s_tgt;
    end

    @(posedge clk);
    cyc++;
    #1;
    if (s_rsp && mq.size() > 0) void'(mq.pop_front());
    if (s_rv && s_rr)
      mq.push_back('{addr: s_ra, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
    drive_next();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(req_valid_o), 32'd0);
    chk({tag, "_req_addr"}, req_addr_o, RESET_PC);
    chk({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
    chk({tag, "_inst"}, inst_o, NOP);
    chk({tag, "_inst_addr"}, inst_addr_o, 32'd0);
  endtask

  task automatic do_reset(input int n, input logic async_chk);
    rst_n = 1'b0;
    jump_en_i = 1'b0; req_ready_i = 1'b0; inst_ready_i = 1'b0; rsp_valid_i = 1'b0;
    if (async_chk) begin
      #1;
      check_reset_outputs("async_rst");
    end
    repeat (n) @(posedge clk);
    #1;
    check_reset_outputs("in_rst");
    mq.delete();
    exp_addr = RESET_PC; exp_pc = RESET_PC;
    jump_prev = 1'b0; rv_prev = 1'b0; rr_prev = 1'b0;
    rst_n = 1'b1;
    drive_next();
  endtask

  task automatic startup_checks();
    cycle();
    chk("wait_cycle_req", 32'(s_rv), 32'd0);
    cycle();
    chk("first_req_valid", 32'(s_rv), 32'd1);
    chk("first_req_addr", s_ra, RESET_PC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic seen;

    // ---- Reset and streaming with 1-cycle memory ----
    lat_min = 1; lat_max = 1; p_rr = 100; p_ir = 100; p_jump = 0;
    do_reset(3, 1'b0);
    startup_checks();
    cycle();  // response to the first request arrives
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stream_valid", 32'(s_iv), 32'd1);
      if (i == 0) chk("first_out_addr", s_ia, RESET_PC);
    end

    // ---- Backpressure: if_id stalls for 10 cycles ----
    p_ir = 0; inst_ready_i = 1'b0;
    repeat (10) cycle();
    chk("bp_req_stalled", 32'(s_rv), 32'd0);
    chk("bp_out_held", 32'(s_iv), 32'd1);
    p_ir = 100; inst_ready_i = 1'b1;
    n0 = n_out;
    repeat (20) cycle();
    chk("bp_drain_progress", 32'(n_out - n0 >= 15), 32'd1);

    // ---- Misaligned redirect target ----
    jump_en_i = 1'b1; jump_addr_i = 32'h8000_0102;
    cycle();
    cycle();
    chk("misaligned_req_valid", 32'(s_rv), 32'd1);
    chk("misaligned_req_addr", s_ra, 32'h8000_0100);
    repeat (8) cycle();

    // ---- Redirect with two requests in flight, 3-cycle memory ----
    lat_min = 3; lat_max = 3;
    do_reset(2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (mq.size() == 2) seen = 1'b1;
    end
    chk("two_in_flight_reached", 32'(seen), 32'd1);
    jump_en_i = 1'b1; jump_addr_i = 32'h8000_0100;
    cycle();
    cycle();
    chk("redirect_req_valid", 32'(s_rv), 32'd1);
    chk("redirect_req_addr", s_ra, 32'h8000_0100);
    seen = s_iv;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = s_iv;
    end
    chk("redirect_output_seen", 32'(seen), 32'd1);
    chk("redirect_first_addr", s_ia, 32'h8000_0100);
    repeat (10) cycle();

    // ---- Reset mid-stream with work in flight and queued ----
    lat_min = 2; lat_max = 2;
    repeat (6) cycle();
    p_ir = 0; inst_ready_i = 1'b0;
    repeat (2) cycle();
    chk("pre_reset_queued", 32'(s_iv), 32'd1);
    p_ir = 100;
    do_reset(3, 1'b1);
    startup_checks();
    n0 = n_out;
    repeat (12) cycle();
    chk("restart_progress", 32'(n_out - n0 >= 6), 32'd1);

    // ---- Randomized traffic with redirects ----
    lat_min = 1; lat_max = 4; p_rr = 70; p_ir = 70; p_jump = 4;
    n0 = n_out;
    repeat (3000) cycle();
    chk("random_progress", 32'(n_out - n0 > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
